// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one dcache access per EX/MEM op, stalls until dhit,
// holds returned load data across external stalls, and tracks halt plus error flags.
module mem_stage_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dMemREN_out,
  input  logic             dMemWEN_out,
  input  logic             Halt_out,
  input  logic [31:0]      aluOutport_out,
  input  logic [31:0]      rdat2_out,
  input  logic             pipe_hold,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      load_data,
  output logic             mem_stall,
  output logic             exmem_writeEN,
  output logic             memwb_writeEN,
  output logic             memwb_flush,
  output logic             halt,
  output logic             misaligned,
  output logic             both_err,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HALTED} state_e;

  state_e            state_q, state_d;
  logic [31:0]       load_q, load_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              timeout_q, timeout_d;
  logic              mis_q, mis_d;
  logic              both_q, both_d;

  logic halted, op, wr, rd, req_phase, stall_int;

  always_comb begin
    halted    = (state_q == HALTED);
    op        = (dMemREN_out | dMemWEN_out) & ~halted;
    wr        = dMemWEN_out;
    rd        = dMemREN_out & ~dMemWEN_out;
    req_phase = (state_q == IDLE) || (state_q == WAIT);
    stall_int = op & ~dhit & (state_q != DONE);
  end

  // Outputs are forced to their reset values while RST is high so a request
  // in flight drops the instant reset asserts, not at the next clock.
  always_comb begin
    dmemREN       = op & req_phase & rd & ~RST;
    dmemWEN       = op & req_phase & wr & ~RST;
    dmemaddr      = RST ? '0 : {aluOutport_out[31:2], 2'b00};
    dmemstore     = RST ? '0 : rdat2_out;
    mem_stall     = stall_int & ~RST;
    memwb_flush   = stall_int & ~RST;
    exmem_writeEN = RST | ~(stall_int | pipe_hold | halted);
    memwb_writeEN = RST | ~pipe_hold | stall_int;
    load_data     = '0;
    if (!RST) begin
      if (dhit && req_phase) load_data = dmemload;
      else if (state_q == DONE) load_data = load_q;
    end
    halt          = halted;
    misaligned    = mis_q;
    both_err      = both_q;
    timeout       = timeout_q;
    stall_cycles  = stall_q;
  end

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    wd_d      = '0;
    stall_d   = stall_q;
    timeout_d = timeout_q;
    mis_d     = mis_q | (op & (aluOutport_out[1:0] != 2'b00));
    both_d    = both_q | (op & dMemREN_out & dMemWEN_out);

    unique case (state_q)
      IDLE: begin
        if (op) begin
          if (dhit) begin
            load_d  = dmemload;
            state_d = pipe_hold ? DONE : IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (Halt_out && !pipe_hold) begin
          state_d = HALTED;
        end
      end
      WAIT: begin
        if (dhit) begin
          load_d  = dmemload;
          state_d = pipe_hold ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!pipe_hold) state_d = IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase

    // Watchdog counts only unbroken WAIT cycles without a hit; it saturates at TIMEOUT.
    if (state_q == WAIT && !dhit) begin
      wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
      if (int'(wd_q) + 1 >= int'(TIMEOUT)) timeout_d = 1'b1;
    end

    if (stall_int && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      load_q    <= '0;
      wd_q      <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
      mis_q     <= 1'b0;
      both_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      wd_q      <= wd_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
      mis_q     <= mis_d;
      both_q    <= both_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 5;
  localparam int          SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, hlt_in, pipe_hold, dhit;
  logic [31:0] alu, rdat2, dmemload;

  logic        dmemREN, dmemWEN, mem_stall, exmem_writeEN, memwb_writeEN, memwb_flush;
  logic        halt, misaligned, both_err, timeout;
  logic [31:0] dmemaddr, dmemstore, load_data;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  mem_stage_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst),
    .dMemREN_out(ren), .dMemWEN_out(wen), .Halt_out(hlt_in),
    .aluOutport_out(alu), .rdat2_out(rdat2),
    .pipe_hold(pipe_hold), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_data(load_data), .mem_stall(mem_stall),
    .exmem_writeEN(exmem_writeEN), .memwb_writeEN(memwb_writeEN), .memwb_flush(memwb_flush),
    .halt(halt), .misaligned(misaligned), .both_err(both_err), .timeout(timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op is either outstanding, already served
  // (data parked while the pipe is held), or the core has halted.
  bit          m_halted, m_served, m_tmo, m_mis, m_both;
  logic [31:0] m_hold;
  int          m_run, m_scnt;

  logic        e_op, e_act, e_ren, e_wen, e_stall, e_exen, e_mwen;
  logic [31:0] e_ld, e_addr, e_store;

  always_comb begin
    e_op    = (ren | wen) & ~m_halted;
    e_act   = e_op & ~m_served;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_stall = 1'b0;
    e_exen  = 1'b1;
    e_mwen  = 1'b1;
    e_ld    = '0;
    e_addr  = '0;
    e_store = '0;
    if (!rst) begin
      e_ren   = e_act & ren & ~wen;
      e_wen   = e_act & wen;
      e_stall = e_act & ~dhit;
      e_exen  = ~(e_stall | pipe_hold | m_halted);
      e_mwen  = ~pipe_hold | e_stall;
      e_addr  = alu & 32'hFFFF_FFFC;
      e_store = rdat2;
      if (!m_halted && !m_served && dhit) e_ld = dmemload;
      else if (m_served) e_ld = m_hold;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted <= 1'b0; m_served <= 1'b0; m_tmo <= 1'b0; m_mis <= 1'b0; m_both <= 1'b0;
      m_hold <= '0; m_run <= 0; m_scnt <= 0;
    end else begin
      if (e_op && alu[1:0] != 2'b00) m_mis <= 1'b1;
      if (e_op && ren && wen) m_both <= 1'b1;
      if (e_stall) begin
        m_run <= m_run + 1;
        // first stalled cycle is the issue cycle; the rest are watchdog cycles
        if (m_run + 1 >= int'(TO) + 1) m_tmo <= 1'b1;
        if (m_scnt < SAT) m_scnt <= m_scnt + 1;
      end else begin
        m_run <= 0;
      end
      if (!m_halted) begin
        if (m_served) begin
          if (!pipe_hold) m_served <= 1'b0;
        end else if (e_op) begin
          if (dhit) begin
            m_hold   <= dmemload;
            m_served <= pipe_hold;
          end
        end else if (hlt_in && !pipe_hold) begin
          m_halted <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmemREN",       32'(dmemREN),       32'(e_ren));
      chk("dmemWEN",       32'(dmemWEN),       32'(e_wen));
      chk("dmemaddr",      dmemaddr,           e_addr);
      chk("dmemstore",     dmemstore,          e_store);
      chk("load_data",     load_data,          e_ld);
      chk("mem_stall",     32'(mem_stall),     32'(e_stall));
      chk("memwb_flush",   32'(memwb_flush),   32'(e_stall));
      chk("exmem_writeEN", 32'(exmem_writeEN), 32'(e_exen));
      chk("memwb_writeEN", 32'(memwb_writeEN), 32'(e_mwen));
      chk("halt",          32'(halt),          32'(m_halted));
      chk("misaligned",    32'(misaligned),    32'(m_mis));
      chk("both_err",      32'(both_err),      32'(m_both));
      chk("timeout",       32'(timeout),       32'(m_tmo));
      chk("stall_cycles",  32'(stall_cycles),  32'(m_scnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic r, input logic w, input logic h,
                         input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; hlt_in = h; alu = a; rdat2 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_ins(0, 0, 0, 0, 0);
    dhit = 1'b0; pipe_hold = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic rand_ins();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 99);
    a = $urandom;
    if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
    if (k < 35)      set_ins(1, 0, 0, a, $urandom);
    else if (k < 65) set_ins(0, 1, 0, a, $urandom);
    else if (k < 72) set_ins(1, 1, 0, a, $urandom);
    else if (k < 75) set_ins(0, 0, 1, a, $urandom);
    else             set_ins(0, 0, 0, a, $urandom);
  endtask

  initial begin
    bit adv;
    int hcnt;
    rst = 1'b1;
    set_ins(0, 0, 0, 0, 0);
    pipe_hold = 1'b0; dhit = 1'b0; dmemload = '0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst exmem_writeEN", 32'(exmem_writeEN), 32'd1);
    chk("rst memwb_writeEN", 32'(memwb_writeEN), 32'd1);
    chk("rst stall_cycles",  32'(stall_cycles),  32'd0);
    cyc();
    rst = 1'b0;

    // load, hit three cycles later
    set_ins(1, 0, 0, 32'h100, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1 mem_stall", 32'(mem_stall), 32'd1);
      chk("t1 exmem_writeEN", 32'(exmem_writeEN), 32'd0);
      chk("t1 dmemREN", 32'(dmemREN), 32'd1);
      cyc();
    end
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1 load_data", load_data, 32'hDEADBEEF);
    chk("t1 mem_stall at hit", 32'(mem_stall), 32'd0);
    cyc();
    set_ins(0, 0, 0, 0, 0); dhit = 1'b0;
    @(negedge clk);
    chk("t1 stall_cycles", 32'(stall_cycles), 32'd3);

    // store with same-cycle hit
    cyc();
    set_ins(0, 1, 0, 32'h204, 32'h12345678); dhit = 1'b1;
    @(negedge clk);
    chk("t2 dmemWEN", 32'(dmemWEN), 32'd1);
    chk("t2 dmemaddr", dmemaddr, 32'h204);
    chk("t2 dmemstore", dmemstore, 32'h12345678);
    chk("t2 mem_stall", 32'(mem_stall), 32'd0);
    cyc();
    set_ins(0, 0, 0, 0, 0); dhit = 1'b0;
    @(negedge clk);
    chk("t2 dmemWEN after", 32'(dmemWEN), 32'd0);

    // load hit under pipe_hold, held two more cycles
    cyc();
    set_ins(1, 0, 0, 32'h300, 0); dhit = 1'b1; dmemload = 32'hCAFEF00D; pipe_hold = 1'b1;
    @(negedge clk);
    chk("t3 load_data hit", load_data, 32'hCAFEF00D);
    cyc();
    dhit = 1'b0; dmemload = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3 dmemREN held", 32'(dmemREN), 32'd0);
      chk("t3 load_data held", load_data, 32'hCAFEF00D);
      cyc();
      if (i == 1) pipe_hold = 1'b0;
    end
    @(negedge clk);
    chk("t3 load_data release", load_data, 32'hCAFEF00D);
    chk("t3 dmemREN release", 32'(dmemREN), 32'd0);
    cyc();
    set_ins(0, 0, 0, 0, 0);

    // halt with no op, then a fresh REN must be ignored
    set_ins(0, 0, 1, 0, 0);
    cyc();
    @(negedge clk);
    chk("t4 halt", 32'(halt), 32'd1);
    chk("t4 exmem_writeEN", 32'(exmem_writeEN), 32'd0);
    cyc();
    set_ins(1, 0, 1, 32'h40, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4 dmemREN", 32'(dmemREN), 32'd0);
      cyc();
    end

    // reset asserted mid-WAIT
    do_reset();
    set_ins(1, 0, 0, 32'h400, 0);
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("t5 dmemREN", 32'(dmemREN), 32'd0);
    chk("t5 mem_stall", 32'(mem_stall), 32'd0);
    chk("t5 exmem_writeEN", 32'(exmem_writeEN), 32'd1);
    chk("t5 stall_cycles", 32'(stall_cycles), 32'd0);
    cyc();
    rst = 1'b0;
    set_ins(0, 0, 0, 0, 0);
    cyc();

    // watchdog: six stalled cycles
    set_ins(1, 0, 0, 32'h500, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6 timeout", 32'(timeout), (i == 5) ? 32'd1 : 32'd0);
      chk("t6 dmemREN", 32'(dmemREN), 32'd1);
      cyc();
    end
    dhit = 1'b1; dmemload = 32'h0BADF00D;
    @(negedge clk);
    chk("t6 stall_cycles", 32'(stall_cycles), 32'd6);
    cyc();
    dhit = 1'b0;
    set_ins(1, 0, 0, 32'h600, 0);
    for (int i = 0; i < 30; i++) cyc();
    @(negedge clk);
    chk("sat stall_cycles", 32'(stall_cycles), 32'(SAT));
    cyc();
    dhit = 1'b1;
    cyc();
    do_reset();

    // randomized traffic; EX/MEM latch only advances when the model says it may
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      adv = e_exen;
      hcnt = m_halted ? hcnt + 1 : 0;
      cyc();
      if (hcnt > 6 || $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        set_ins(0, 0, 0, 0, 0);
        hcnt = 0;
      end else begin
        rst = 1'b0;
        if (adv) rand_ins();
      end
      pipe_hold = ($urandom_range(0, 3) == 0);
      dhit      = ($urandom_range(0, 9) < 4);
      dmemload  = $urandom;
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
